// File: rtl/depth_pkg.sv
// depth_pkg: depth compare function codes and depth test FSM state encoding
package depth_pkg;
    typedef enum logic [2:0] {
        Z_NEVER, Z_LESS, Z_LEQUAL, Z_GREATER, Z_GEQUAL, Z_EQUAL, Z_NOTEQUAL, Z_ALWAYS
    } z_func_t;
    localparam logic [2:0] Z_FUNC_NEVER    = 3'd0;
    localparam logic [2:0] Z_FUNC_LESS     = 3'd1;
    localparam logic [2:0] Z_FUNC_LEQUAL   = 3'd2;
    localparam logic [2:0] Z_FUNC_GREATER  = 3'd3;
    localparam logic [2:0] Z_FUNC_GEQUAL   = 3'd4;
    localparam logic [2:0] Z_FUNC_EQUAL    = 3'd5;
    localparam logic [2:0] Z_FUNC_NOTEQUAL = 3'd6;
    localparam logic [2:0] Z_FUNC_ALWAYS   = 3'd7;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WRITE, EMIT, CLEAR} state_t;
endpackage

// File: rtl/depth_compare.sv
// depth_compare: unsigned depth comparison a (incoming) against b (stored)
//   a, b : depth values; func : compare function; pass : comparison result
module depth_compare
    import depth_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  z_func_t      func,
    output logic         pass
);
    always_comb pass = func == Z_LESS     ? a <  b :
                       func == Z_LEQUAL   ? a <= b :
                       func == Z_GREATER  ? a >  b :
                       func == Z_GEQUAL   ? a >= b :
                       func == Z_EQUAL    ? a == b :
                       func == Z_NOTEQUAL ? a != b :
                       func == Z_ALWAYS;
endmodule

// File: rtl/depth_test_unit.sv
// depth_test_unit: streaming per-fragment depth test and Z buffer clear
//   frag_*      : fragment input stream (valid/ready, x, y, z)
//   out_*       : result stream (valid/ready, x, y, pass)
//   rd_req_* / rd_resp_* : Z buffer read request and response
//   wr_*        : Z buffer write (fragment update or clear)
//   base_addr_i, z_func_i, z_write_en_i, clear_i, clear_value_i : control
//   busy_o, clear_done_o : status
module depth_test_unit
    import depth_pkg::*;
#(
    parameter int Z_SIZE    = 16,
    parameter int X_RES     = 64,
    parameter int Y_RES     = 64,
    parameter int ADDR_SIZE = 32,
    parameter int XW        = X_RES > 1 ? $clog2(X_RES) : 1,
    parameter int YW        = Y_RES > 1 ? $clog2(Y_RES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_SIZE-1:0] base_addr_i,
    input  logic [2:0]           z_func_i,
    input  logic                 z_write_en_i,
    input  logic                 clear_i,
    input  logic [Z_SIZE-1:0]    clear_value_i,
    input  logic                 frag_valid_i,
    output logic                 frag_ready_o,
    input  logic [XW-1:0]        frag_x_i,
    input  logic [YW-1:0]        frag_y_i,
    input  logic [Z_SIZE-1:0]    frag_z_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [XW-1:0]        out_x_o,
    output logic [YW-1:0]        out_y_o,
    output logic                 out_pass_o,
    output logic                 rd_req_valid_o,
    input  logic                 rd_req_ready_i,
    output logic [ADDR_SIZE-1:0] rd_addr_o,
    input  logic                 rd_resp_valid_i,
    output logic                 rd_resp_ready_o,
    input  logic [Z_SIZE-1:0]    rd_data_i,
    output logic                 wr_valid_o,
    input  logic                 wr_ready_i,
    output logic [ADDR_SIZE-1:0] wr_addr_o,
    output logic [Z_SIZE-1:0]    wr_data_o,
    output logic                 busy_o,
    output logic                 clear_done_o
);
    localparam int NPIX = X_RES * Y_RES;
    localparam int CW   = $clog2(NPIX + 1);
    state_t               state, state_d, acc_state;
    logic [XW-1:0]        x_q;
    logic [YW-1:0]        y_q;
    logic [Z_SIZE-1:0]    data_q;
    logic [ADDR_SIZE-1:0] addr_q, frag_addr;
    logic [CW-1:0]        cnt;
    z_func_t              func_q, f_in;
    logic                 we_q, pass_q, done_q, oob, acc_pass, cmp_pass, last;
    assign f_in      = z_func_t'(z_func_i);
    assign oob       = 32'(frag_x_i) >= X_RES || 32'(frag_y_i) >= Y_RES;
    assign frag_addr = base_addr_i + ADDR_SIZE'(frag_y_i) * ADDR_SIZE'(X_RES) + ADDR_SIZE'(frag_x_i);
    assign acc_pass  = !oob && f_in == Z_ALWAYS;
    // Out-of-range, NEVER and ALWAYS are resolved at accept without reading memory
    assign acc_state = oob || f_in == Z_NEVER ? EMIT :
                       f_in == Z_ALWAYS ? (z_write_en_i ? WRITE : EMIT) : RD_REQ;
    assign last      = cnt == CW'(NPIX - 1);
    depth_compare #(.W(Z_SIZE)) u_cmp (
        .a    (data_q),
        .b    (rd_data_i),
        .func (func_q),
        .pass (cmp_pass)
    );
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = clear_i ? CLEAR : frag_valid_i ? acc_state : IDLE;
            RD_REQ:  state_d = rd_req_ready_i ? RD_WAIT : RD_REQ;
            RD_WAIT: state_d = rd_resp_valid_i ? (cmp_pass && we_q ? WRITE : EMIT) : RD_WAIT;
            WRITE:   state_d = wr_ready_i ? EMIT : WRITE;
            EMIT:    state_d = out_ready_i ? IDLE : EMIT;
            CLEAR:   state_d = wr_ready_i && last ? IDLE : CLEAR;
            default: state_d = IDLE;
        endcase
    end
    // data_q holds the fragment depth during a test and the clear value during a clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            data_q <= '0;
            addr_q <= '0;
            cnt    <= '0;
            func_q <= Z_NEVER;
            we_q   <= 1'b0;
            pass_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_i) begin
                        cnt    <= '0;
                        addr_q <= base_addr_i;
                        data_q <= clear_value_i;
                    end else if (frag_valid_i) begin
                        x_q    <= frag_x_i;
                        y_q    <= frag_y_i;
                        data_q <= frag_z_i;
                        func_q <= f_in;
                        we_q   <= z_write_en_i;
                        addr_q <= frag_addr;
                        pass_q <= acc_pass;
                    end
                end
                RD_WAIT: if (rd_resp_valid_i) pass_q <= cmp_pass;
                CLEAR: begin
                    if (wr_ready_i) begin
                        addr_q <= addr_q + ADDR_SIZE'(1);
                        cnt    <= cnt + CW'(1);
                        done_q <= last;
                    end
                end
                default: ;
            endcase
        end
    end
    assign frag_ready_o    = state == IDLE && !clear_i && !rst_i;
    assign rd_req_valid_o  = state == RD_REQ;
    assign rd_resp_ready_o = state == RD_WAIT;
    assign wr_valid_o      = state == WRITE || state == CLEAR;
    assign out_valid_o     = state == EMIT;
    assign busy_o          = state != IDLE;
    assign rd_addr_o       = addr_q;
    assign wr_addr_o       = addr_q;
    assign wr_data_o       = data_q;
    assign out_x_o         = x_q;
    assign out_y_o         = y_q;
    assign out_pass_o      = pass_q;
    assign clear_done_o    = done_q;
endmodule
